insertion_sort_ctrl: RTL and testbench

FSM controller that sequences the insertion-sort datapath (registers i, j, elem2insert, elem2compare plus address/data muxes) over an in-place array in memory.
- Drives the datapath load/clear/select strobes and the memory read/write channel handshakes.
- Consumes the datapath comparison flags.
- Exposes a start/busy/done/err interface to the system.
- Algorithm: for i=1..n-1 { key=a[i]; j=i-1; while (j>=0 && !(key>a[j])) { a[j+1]=a[j]; j-- } a[j+1]=key }.

---
 rtl/insertion_sort_ctrl_pkg.sv | 30 +++
 rtl/insertion_sort_ctrl_if.sv | 26 ++
 rtl/insertion_sort_ctrl_mem_wr_hs.sv | 42 ++++
 rtl/insertion_sort_ctrl.sv | 148 ++++++++++++++
 tb/tb_insertion_sort_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/insertion_sort_ctrl_pkg.sv
// Shared types and encodings for the insertion-sort controller.
package sort_ctrl_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned RESP_OKAY = 0;

  typedef enum logic [STATE_W-1:0] {
    IDLE, INIT, CHK_I, RD_KEY_AR, RD_KEY_R, CHK_J, RD_CMP_AR, RD_CMP_R,
    CMP, WR_SHIFT, WR_SHIFT_B, WR_KEY, WR_KEY_B, DONE
  } state_e;

  // Register-input selects
  localparam logic SEL_ONE       = 1'b0;
  localparam logic SEL_I_PLUS_1  = 1'b1;
  localparam logic SEL_I_MINUS_1 = 1'b0;
  localparam logic SEL_J_MINUS_1 = 1'b1;

  // Memory address/data selects
  localparam logic SEL_I           = 1'b0;
  localparam logic SEL_J           = 1'b1;
  localparam logic WA_SEL_J        = 1'b0;
  localparam logic WA_SEL_J_PLUS_1 = 1'b1;
  localparam logic SEL_INS         = 1'b0;
  localparam logic SEL_CMP         = 1'b1;

  function automatic logic is_wr_req(state_e s);
    return (s == WR_SHIFT) || (s == WR_KEY);
  endfunction

endpackage

// File: rtl/insertion_sort_ctrl_if.sv
// Memory read/write channel handshakes between the controller and memory.
interface insertion_sort_ctrl_if #(
  parameter int unsigned RESP_WDTH = 1
) ();
  logic                 ar_valid;
  logic                 ar_ready;
  logic                 r_valid;
  logic                 r_ready;
  logic                 aw_valid;
  logic                 aw_ready;
  logic                 w_valid;
  logic                 w_ready;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;

  modport master (
    output ar_valid, r_ready, aw_valid, w_valid, b_ready,
    input  ar_ready, r_valid, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, r_ready, aw_valid, w_valid, b_ready,
    output ar_ready, r_valid, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/insertion_sort_ctrl_mem_wr_hs.sv
// Write request tracker: aw and w are accepted independently; flags when both are done.
module mem_wr_hs (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic aw_ready,
  input  logic w_ready,
  output logic aw_valid_c,
  output logic w_valid_c,
  output logic wr_done_c
);

  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  always_comb begin
    aw_valid_c = active & ~aw_done_q;
    w_valid_c  = active & ~w_done_q;
    // Complete in the cycle the last outstanding ready arrives
    wr_done_c  = active & (aw_done_q | aw_ready) & (w_done_q | w_ready);
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    if (wr_done_c || !active) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_valid_c && aw_ready) aw_done_d = 1'b1;
      if (w_valid_c && w_ready)   w_done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/insertion_sort_ctrl.sv
// Insertion-sort sequencer: drives datapath strobes/selects and one-at-a-time memory traffic.
module insertion_sort_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned RESP_WDTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  input  logic elem2insert_gt_elem2compare,
  input  logic j_gte_0,
  input  logic i_lt_arr_size,
  output logic sl_1_incd_to_i,
  output logic ld_i,
  output logic clr_i,
  output logic sl_i_minus_1_decrd_to_j,
  output logic ld_j,
  output logic clr_j,
  output logic ld_elem2insert,
  output logic clr_elem2insert,
  output logic ld_elem2compare,
  output logic clr_elem2compare,
  output logic sl_i_j_to_arr_ra,
  output logic sl_j_j_plus_1_to_arr_wa,
  output logic sl_elem2insert_elem2compare_to_arr_w,
  insertion_sort_ctrl_if.master mem
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   wr_active, aw_valid_c, w_valid_c, wr_done_c, resp_bad;

  assign wr_active = is_wr_req(state_q);
  assign resp_bad  = (mem.b_resp != RESP_WDTH'(RESP_OKAY));

  mem_wr_hs u_wr_hs (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (wr_active),
    .aw_ready   (mem.aw_ready),
    .w_ready    (mem.w_ready),
    .aw_valid_c (aw_valid_c),
    .w_valid_c  (w_valid_c),
    .wr_done_c  (wr_done_c)
  );

  assign mem.aw_valid = aw_valid_c;
  assign mem.w_valid  = w_valid_c;
  assign err          = err_q;

  always_comb begin
    state_d                              = state_q;
    err_d                                = err_q;
    busy                                 = (state_q != IDLE);
    done                                 = (state_q == DONE);
    ld_i                                 = 1'b0;
    clr_i                                = 1'b0;
    ld_j                                 = 1'b0;
    clr_j                                = 1'b0;
    ld_elem2insert                       = 1'b0;
    clr_elem2insert                      = 1'b0;
    ld_elem2compare                      = 1'b0;
    clr_elem2compare                     = 1'b0;
    mem.ar_valid                         = 1'b0;
    mem.r_ready                          = 1'b0;
    mem.b_ready                          = 1'b0;
    // Selects depend on state alone so they never move mid-state
    sl_1_incd_to_i                       = (state_q == WR_KEY_B) ? SEL_I_PLUS_1 : SEL_ONE;
    sl_i_minus_1_decrd_to_j              = (state_q == WR_SHIFT_B) ? SEL_J_MINUS_1 : SEL_I_MINUS_1;
    sl_i_j_to_arr_ra                     = (state_q inside {RD_CMP_AR, RD_CMP_R}) ? SEL_J : SEL_I;
    sl_j_j_plus_1_to_arr_wa              = (state_q inside {WR_SHIFT, WR_SHIFT_B, WR_KEY, WR_KEY_B})
                                           ? WA_SEL_J_PLUS_1 : WA_SEL_J;
    sl_elem2insert_elem2compare_to_arr_w = (state_q inside {WR_SHIFT, WR_SHIFT_B}) ? SEL_CMP : SEL_INS;

    unique case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        err_d   = 1'b0;
      end
      INIT: begin
        clr_j            = 1'b1;
        clr_elem2insert  = 1'b1;
        clr_elem2compare = 1'b1;
        ld_i             = 1'b1;
        state_d          = CHK_I;
      end
      CHK_I:     state_d = i_lt_arr_size ? RD_KEY_AR : DONE;
      RD_KEY_AR: begin
        mem.ar_valid = 1'b1;
        if (mem.ar_ready) state_d = RD_KEY_R;
      end
      RD_KEY_R: begin
        mem.r_ready = 1'b1;
        if (mem.r_valid) begin
          ld_elem2insert = 1'b1;
          ld_j           = 1'b1;
          state_d        = CHK_J;
        end
      end
      CHK_J:     state_d = j_gte_0 ? RD_CMP_AR : WR_KEY;
      RD_CMP_AR: begin
        mem.ar_valid = 1'b1;
        if (mem.ar_ready) state_d = RD_CMP_R;
      end
      RD_CMP_R: begin
        mem.r_ready = 1'b1;
        if (mem.r_valid) begin
          ld_elem2compare = 1'b1;
          state_d         = CMP;
        end
      end
      CMP:       state_d = elem2insert_gt_elem2compare ? WR_KEY : WR_SHIFT;
      WR_SHIFT:  if (wr_done_c) state_d = WR_SHIFT_B;
      WR_KEY:    if (wr_done_c) state_d = WR_KEY_B;
      WR_SHIFT_B, WR_KEY_B: begin
        mem.b_ready = 1'b1;
        if (mem.b_valid) begin
          if (resp_bad) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (state_q == WR_SHIFT_B) begin
            ld_j    = 1'b1;
            state_d = CHK_J;
          end else begin
            ld_i    = 1'b1;
            state_d = CHK_I;
          end
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_insertion_sort_ctrl.sv
// Bench for insertion_sort_ctrl: behavioural datapath + memory, reference-sort scoreboard.
module tb_insertion_sort_ctrl;

  localparam int unsigned RESP_WDTH = 1;
  localparam int unsigned N_VEC     = 8;

  typedef struct packed {
    logic [2:0]      size;
    logic [1:0]      mode;   // 0 zero-wait, 1 random stalls, 2 w lags aw, 3 aw lags w
    logic [3:0][7:0] init;
    logic [3:0][7:0] fin;
    logic [7:0]      n_rd;
    logic [7:0]      n_wr;
  } vec_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n, start;
  logic busy, done, err;
  logic gt_flag, j_ge_flag, i_lt_flag;
  logic sl_i, ld_i, clr_i, sl_j, ld_j, clr_j;
  logic ld_e2i, clr_e2i, ld_e2c, clr_e2c;
  logic sl_ra, sl_wa, sl_wd;

  always #5 clk = ~clk;

  insertion_sort_ctrl_if #(.RESP_WDTH(RESP_WDTH)) mem_if ();

  insertion_sort_ctrl #(.RESP_WDTH(RESP_WDTH)) dut (
    .clk                                  (clk),
    .rst_n                                (rst_n),
    .start                                (start),
    .busy                                 (busy),
    .done                                 (done),
    .err                                  (err),
    .elem2insert_gt_elem2compare          (gt_flag),
    .j_gte_0                              (j_ge_flag),
    .i_lt_arr_size                        (i_lt_flag),
    .sl_1_incd_to_i                       (sl_i),
    .ld_i                                 (ld_i),
    .clr_i                                (clr_i),
    .sl_i_minus_1_decrd_to_j              (sl_j),
    .ld_j                                 (ld_j),
    .clr_j                                (clr_j),
    .ld_elem2insert                       (ld_e2i),
    .clr_elem2insert                      (clr_e2i),
    .ld_elem2compare                      (ld_e2c),
    .clr_elem2compare                     (clr_e2c),
    .sl_i_j_to_arr_ra                     (sl_ra),
    .sl_j_j_plus_1_to_arr_wa              (sl_wa),
    .sl_elem2insert_elem2compare_to_arr_w (sl_wd),
    .mem                                  (mem_if)
  );

  logic [20:0] all_out;
  assign all_out = {busy, done, err, sl_i, ld_i, clr_i, sl_j, ld_j, clr_j,
                    ld_e2i, clr_e2i, ld_e2c, clr_e2c, sl_ra, sl_wa, sl_wd,
                    mem_if.ar_valid, mem_if.r_ready, mem_if.aw_valid,
                    mem_if.w_valid, mem_if.b_ready};

  // Behavioural datapath registers and memory
  int arr_size;
  int mem [4];
  int i_r, j_r, key_r, cmp_r;
  assign gt_flag   = (key_r > cmp_r);
  assign j_ge_flag = (j_r >= 0);
  assign i_lt_flag = (i_r < arr_size);

  // Memory slave state
  int  mode, err_at;
  bit  rd_pend, rd_is_cmp, hold_r, aw_got, w_got, b_pend, b_err;
  int  rd_addr, rd_wait, wr_addr, wr_data, aw_cnt, w_cnt, b_wait;
  bit  ar_hold, aw_hold, w_hold, saw_cmp_ar;
  logic ra_prev, wa_prev, wd_prev;
  int  n_rd, n_wr, n_done;
  bit  last_done;

  int  exp_rd_q [$];
  wr_t exp_wr_q [$];
  vec_t vecs [N_VEC];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task automatic set_vec(input int k, input int size, input int md,
                         input int a0, input int a1, input int a2, input int a3,
                         input int f0, input int f1, input int f2, input int f3,
                         input int nr, input int nw);
    vecs[k].size    = 3'(size);
    vecs[k].mode    = 2'(md);
    vecs[k].init[0] = 8'(a0); vecs[k].init[1] = 8'(a1);
    vecs[k].init[2] = 8'(a2); vecs[k].init[3] = 8'(a3);
    vecs[k].fin[0]  = 8'(f0); vecs[k].fin[1]  = 8'(f1);
    vecs[k].fin[2]  = 8'(f2); vecs[k].fin[3]  = 8'(f3);
    vecs[k].n_rd    = 8'(nr);
    vecs[k].n_wr    = 8'(nw);
  endtask

  // Reference algorithm: expected read addresses and (addr,data) writes
  task automatic build_ref(input int n);
    int  a [4];
    int  key, j;
    wr_t e;
    for (int k = 0; k < 4; k++) a[k] = mem[k];
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 1; i < n; i++) begin
      key = a[i];
      exp_rd_q.push_back(i);
      j = i - 1;
      while (j >= 0) begin
        exp_rd_q.push_back(j);
        if (key > a[j]) break;
        a[j+1] = a[j];
        e.addr = j + 1; e.data = a[j];
        exp_wr_q.push_back(e);
        j--;
      end
      a[j+1] = key;
      e.addr = j + 1; e.data = key;
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic slave_reset();
    rd_pend = 0; rd_is_cmp = 0; hold_r = 0; aw_got = 0; w_got = 0;
    b_pend = 0; b_err = 0; rd_addr = 0; rd_wait = 0; aw_cnt = 0; w_cnt = 0;
    b_wait = 0; ar_hold = 0; aw_hold = 0; w_hold = 0; saw_cmp_ar = 0;
    last_done = 0;
  endtask

  // One clock: drive at negedge, sample 1 later, update model 1 after posedge
  task automatic cycle();
    bit  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int  i_nx, j_nx, key_nx, cmp_nx, rdata, addr, exp_a;
    wr_t e;
    @(negedge clk);
    mem_if.ar_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_if.r_valid  = rd_pend && (rd_wait == 0) && !(hold_r && rd_is_cmp);
    mem_if.aw_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 3) ? (aw_cnt >= 2) : 1'b1;
    mem_if.w_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 2) ? (w_cnt >= 2) : 1'b1;
    mem_if.b_valid  = b_pend && (b_wait == 0);
    mem_if.b_resp   = RESP_WDTH'(b_err);
    #1;
    if (ar_hold) begin
      check("ar_valid_held", int'(mem_if.ar_valid), 1);
      check("ra_sel_stable", int'(sl_ra), int'(ra_prev));
    end
    if (aw_hold) begin
      check("aw_valid_held", int'(mem_if.aw_valid), 1);
      check("wa_sel_stable", int'(sl_wa), int'(wa_prev));
    end
    if (w_hold) begin
      check("w_valid_held", int'(mem_if.w_valid), 1);
      check("wd_sel_stable", int'(sl_wd), int'(wd_prev));
    end
    ar_hold = mem_if.ar_valid && !mem_if.ar_ready;
    aw_hold = mem_if.aw_valid && !mem_if.aw_ready;
    w_hold  = mem_if.w_valid && !mem_if.w_ready;
    ra_prev = sl_ra; wa_prev = sl_wa; wd_prev = sl_wd;

    ar_hs = mem_if.ar_valid && mem_if.ar_ready;
    r_hs  = mem_if.r_valid && mem_if.r_ready;
    aw_hs = mem_if.aw_valid && mem_if.aw_ready;
    w_hs  = mem_if.w_valid && mem_if.w_ready;
    b_hs  = mem_if.b_valid && mem_if.b_ready;
    rdata = (rd_addr >= 0 && rd_addr < 4) ? mem[rd_addr] : 0;
    i_nx = i_r; j_nx = j_r; key_nx = key_r; cmp_nx = cmp_r;

    if (r_hs) rd_pend = 0;
    else if (rd_pend && !mem_if.r_valid && rd_wait > 0) rd_wait--;
    if (b_hs) b_pend = 0;
    else if (b_pend && !mem_if.b_valid && b_wait > 0) b_wait--;

    if (ar_hs) begin
      check("one_outstanding_rd", int'(rd_pend || b_pend || aw_got || w_got), 0);
      addr  = sl_ra ? j_r : i_r;
      exp_a = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : -1;
      check($sformatf("rd_addr#%0d", n_rd), addr, exp_a);
      n_rd++;
      rd_pend = 1; rd_addr = addr; rd_is_cmp = sl_ra;
      rd_wait = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
      if (sl_ra) saw_cmp_ar = 1;
    end

    if (aw_hs) begin
      check("aw_dup", int'(aw_got), 0);
      check("one_outstanding_wr", int'(rd_pend || b_pend), 0);
      aw_got = 1; wr_addr = sl_wa ? j_r + 1 : j_r;
    end else if (mem_if.aw_valid) aw_cnt++;
    if (w_hs) begin
      check("w_dup", int'(w_got), 0);
      w_got = 1; wr_data = sl_wd ? cmp_r : key_r;
    end else if (mem_if.w_valid) w_cnt++;
    if (aw_got && w_got) begin
      if (exp_wr_q.size() > 0) e = exp_wr_q.pop_front();
      else begin e.addr = -1; e.data = -1; end
      check($sformatf("wr_addr#%0d", n_wr), wr_addr, e.addr);
      check($sformatf("wr_data#%0d", n_wr), wr_data, e.data);
      if (wr_addr >= 0 && wr_addr < 4) mem[wr_addr] = wr_data;
      n_wr++;
      b_pend = 1; b_err = (n_wr == err_at);
      b_wait = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
      aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
    end

    if (clr_i)   i_nx   = 0;
    if (ld_i)    i_nx   = sl_i ? i_r + 1 : 1;
    if (clr_j)   j_nx   = 0;
    if (ld_j)    j_nx   = sl_j ? j_r - 1 : i_r - 1;
    if (clr_e2i) key_nx = 0;
    if (ld_e2i)  key_nx = rdata;
    if (clr_e2c) cmp_nx = 0;
    if (ld_e2c)  cmp_nx = rdata;
    if (done) n_done++;
    last_done = done;

    @(posedge clk);
    #1;
    i_r = i_nx; j_r = j_nx; key_r = key_nx; cmp_r = cmp_nx;
  endtask

  task automatic load_vec(input int k, input int e_at);
    arr_size = int'(vecs[k].size);
    mode     = int'(vecs[k].mode);
    err_at   = e_at;
    for (int x = 0; x < 4; x++) mem[x] = int'(vecs[k].init[x]);
    build_ref(arr_size);
    n_rd = 0; n_wr = 0; n_done = 0;
  endtask

  task automatic run_sort(output int done_cyc);
    start = 1'b1;
    cycle();
    start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      cycle();
      if (last_done) done_cyc = c;
    end
    check("done_seen", int'(done_cyc != 0), 1);
    for (int c = 0; c < 3; c++) cycle();
  endtask

  task automatic check_result(input int k, input int done_cyc);
    check($sformatf("v%0d_reads", k),  n_rd,   int'(vecs[k].n_rd));
    check($sformatf("v%0d_writes", k), n_wr,   int'(vecs[k].n_wr));
    check($sformatf("v%0d_done_cnt", k), n_done, 1);
    check($sformatf("v%0d_busy_after", k), int'(busy), 0);
    check($sformatf("v%0d_err", k), int'(err), 0);
    check($sformatf("v%0d_rd_left", k), exp_rd_q.size(), 0);
    check($sformatf("v%0d_wr_left", k), exp_wr_q.size(), 0);
    for (int x = 0; x < 4; x++)
      check($sformatf("v%0d_mem[%0d]", k, x), mem[x], int'(vecs[k].fin[x]));
    if (vecs[k].size <= 1) check($sformatf("v%0d_done_cycle", k), done_cyc, 3);
  endtask

  initial begin
    int dc, rd_before;
    //      k size mode  init         fin          rd wr
    set_vec(0, 1, 0,  5, 0, 0, 9,   5, 0, 0, 9,   0, 0);
    set_vec(1, 3, 0,  3, 1, 2, 9,   1, 2, 3, 9,   5, 4);
    set_vec(2, 4, 0,  1, 2, 3, 4,   1, 2, 3, 4,   6, 3);
    set_vec(3, 3, 2,  3, 1, 2, 9,   1, 2, 3, 9,   5, 4);
    set_vec(4, 3, 3,  3, 1, 2, 9,   1, 2, 3, 9,   5, 4);
    set_vec(5, 4, 1,  4, 3, 2, 1,   1, 2, 3, 4,   9, 9);
    set_vec(6, 3, 1,  2, 2, 2, 9,   2, 2, 2, 9,   5, 5);
    set_vec(7, 0, 0,  7, 0, 0, 0,   7, 0, 0, 0,   0, 0);

    rst_n = 1'b0; start = 1'b0;
    mem_if.ar_ready = 1'b0; mem_if.r_valid = 1'b0; mem_if.aw_ready = 1'b0;
    mem_if.w_ready = 1'b0; mem_if.b_valid = 1'b0; mem_if.b_resp = '0;
    i_r = 0; j_r = 0; key_r = 0; cmp_r = 0; arr_size = 0; mode = 0; err_at = 0;
    for (int x = 0; x < 4; x++) mem[x] = 0;
    slave_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(all_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("idle_busy", int'(busy), 0);

    for (int k = 0; k < int'(N_VEC); k++) begin
      load_vec(k, 0);
      run_sort(dc);
      check_result(k, dc);
    end

    // Error response on the second write
    load_vec(1, 2);
    run_sort(dc);
    check("err_set", int'(err), 1);
    check("err_done_cnt", n_done, 1);
    check("err_reads", n_rd, 2);
    check("err_writes", n_wr, 2);
    check("err_mem0", mem[0], 1);
    check("err_mem1", mem[1], 3);
    check("err_mem2", mem[2], 2);
    for (int c = 0; c < 5; c++) cycle();
    check("err_no_traffic", n_rd + n_wr, 4);
    check("err_sticky", int'(err), 1);
    check("err_idle", int'(busy), 0);
    load_vec(0, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("err_cleared_on_start", int'(err), 0);
    for (int c = 0; c < 6; c++) cycle();
    check("post_err_done_cnt", n_done, 1);

    // Reset while waiting in RD_CMP_R with the compare read already accepted
    load_vec(1, 0);
    hold_r = 1;
    saw_cmp_ar = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 50 && !saw_cmp_ar; c++) cycle();
    check("rst_reached_cmp_read", int'(saw_cmp_ar), 1);
    check("rst_pre_r_ready", int'(mem_if.r_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", int'(all_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    slave_reset();
    rd_before = n_rd;
    for (int c = 0; c < 6; c++) cycle();
    check("rst_stays_idle", int'(busy), 0);
    check("rst_no_replay", n_rd, rd_before);
    check("rst_no_writes", n_wr, 0);

    load_vec(1, 0);
    run_sort(dc);
    check_result(1, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
